// File: rtl/multi_sel_collect_if.sv
`default_nettype none
// ============================================================================
//  Module   : multi_sel_collect_if
//  Purpose  : Bundles the product-stream input and the result handshake of
//             multi_sel_collect. The master side is the environment
//             (upstream producer plus result consumer). The slave side is
//             the collector itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface multi_sel_collect_if #(
  parameter int IN_W  = 11,
  parameter int D_W   = 8,
  parameter int SUM_W = 13
);
  logic             in_grant;
  logic [IN_W-1:0]  in_data;
  logic             res_valid;
  logic             res_ready;
  logic [D_W-1:0]   res_d;
  logic [SUM_W-1:0] res_sum;
  logic             res_err;
  logic [7:0]       drop_cnt;
  logic [7:0]       abort_cnt;

  modport master (
    output in_grant, in_data, res_ready,
    input  res_valid, res_d, res_sum, res_err, drop_cnt, abort_cnt
  );

  modport slave (
    input  in_grant, in_data, res_ready,
    output res_valid, res_d, res_sum, res_err, drop_cnt, abort_cnt
  );
endinterface
`default_nettype wire

// File: rtl/multi_sel_collect.sv
`default_nettype none
// ============================================================================
//  Module   : multi_sel_collect
//  Purpose  : Reassembles grant-framed groups of four product words
//             (d*1, d*3, d*7, d*8). Each group is checked for consistency
//             and summed (d*19). Results are queued in a first-word-fall-
//             through FIFO behind a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_sel_collect #(
  parameter int IN_W       = 11,
  parameter int D_W        = 8,
  parameter int SUM_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,   // asynchronous, active low
  multi_sel_collect_if.slave bus
);

  localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [SUM_W-1:0] C_MUL3  = SUM_W'(3);
  localparam logic [SUM_W-1:0] C_MUL7  = SUM_W'(7);
  localparam logic [SUM_W-1:0] C_MUL8  = SUM_W'(8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P3   = 2'd1,
    S_P7   = 2'd2,
    S_P8   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   x1_q, x1_d, x3_q, x3_d, x7_q, x7_d;
  logic [7:0]        drop_q, drop_d, abort_q, abort_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [D_W-1:0]    mem_d_q   [FIFO_DEPTH];
  logic [SUM_W-1:0]  mem_sum_q [FIFO_DEPTH];
  logic              mem_err_q [FIFO_DEPTH];

  logic              complete;
  logic              pop, push, full, drop;
  logic [SUM_W-1:0]  x1e, x3e, x7e, x8e;
  logic [SUM_W-1:0]  ent_sum;
  logic              ent_err;

  // The entry is built from the three captured words and the live x8 word.
  assign x1e     = SUM_W'(x1_q);
  assign x3e     = SUM_W'(x3_q);
  assign x7e     = SUM_W'(x7_q);
  assign x8e     = SUM_W'(bus.in_data);
  assign ent_sum = x1e + x3e + x7e + x8e;
  assign ent_err = (x1_q[IN_W-1:D_W] != '0)
                 | (x3e != x1e * C_MUL3)
                 | (x7e != x1e * C_MUL7)
                 | (x8e != x1e * C_MUL8);

  // Group framing FSM: a grant always restarts a group and may abort a partial one.
  always_comb begin
    state_d  = state_q;
    x1_d     = x1_q;
    x3_d     = x3_q;
    x7_d     = x7_q;
    abort_d  = abort_q;
    complete = 1'b0;
    if (bus.in_grant) begin
      x1_d    = bus.in_data;
      state_d = S_P3;
      if ((state_q != S_IDLE) && (abort_q != 8'hFF)) begin
        abort_d = abort_q + 8'd1;
      end
    end else begin
      case (state_q)
        S_P3: begin
          x3_d    = bus.in_data;
          state_d = S_P7;
        end
        S_P7: begin
          x7_d    = bus.in_data;
          state_d = S_P8;
        end
        S_P8: begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping: a pop frees the slot that a simultaneous push needs.
  always_comb begin
    pop      = (count_q != '0) & bus.res_ready;
    full     = (count_q == C_DEPTH);
    push     = complete & (~full | pop);
    drop     = complete & full & ~pop;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    drop_d = drop_q;
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Control and capture state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      x1_q     <= '0;
      x3_q     <= '0;
      x7_q     <= '0;
      drop_q   <= '0;
      abort_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      x1_q     <= x1_d;
      x3_q     <= x3_d;
      x7_q     <= x7_d;
      drop_q   <= drop_d;
      abort_q  <= abort_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only observed while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d_q[wr_ptr_q]   <= x1_q[D_W-1:0];
      mem_sum_q[wr_ptr_q] <= ent_sum;
      mem_err_q[wr_ptr_q] <= ent_err;
    end
  end

  assign bus.res_valid = (count_q != '0);
  assign bus.res_d     = bus.res_valid ? mem_d_q[rd_ptr_q]   : '0;
  assign bus.res_sum   = bus.res_valid ? mem_sum_q[rd_ptr_q] : '0;
  assign bus.res_err   = bus.res_valid ? mem_err_q[rd_ptr_q] : 1'b0;
  assign bus.drop_cnt  = drop_q;
  assign bus.abort_cnt = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_sel_collect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_sel_collect
//  Purpose  : Self-checking bench for multi_sel_collect. It runs directed
//             groups and then randomized traffic. A queue-based reference
//             model is compared against the DUT on every falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_sel_collect;

  localparam int IN_W  = 11;
  localparam int D_W   = 8;
  localparam int SUM_W = 13;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  multi_sel_collect_if #(.IN_W(IN_W), .D_W(D_W), .SUM_W(SUM_W)) bus ();

  multi_sel_collect #(
    .IN_W(IN_W), .D_W(D_W), .SUM_W(SUM_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int d;
    int sum;
    int err;
  } entry_t;

  entry_t m_fifo[$];
  int     m_grp[$];
  int     m_drop  = 0;
  int     m_abort = 0;

  function automatic entry_t make_entry(int x1, int x3, int x7, int x8);
    entry_t e;
    e.d   = x1 % 256;
    e.sum = x1 + x3 + x7 + x8;
    e.err = ((x1 > 255) || (x3 != (3 * x1) % 8192) ||
             (x7 != (7 * x1) % 8192) || (x8 != (8 * x1) % 8192)) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The model tracks the words gathered since the last grant and the queued results.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_fifo.delete();
      m_grp.delete();
      m_drop  = 0;
      m_abort = 0;
    end else begin
      automatic bit     do_pop = (m_fifo.size() != 0) && (bus.res_ready === 1'b1);
      automatic bit     done   = 1'b0;
      automatic entry_t e;
      if (bus.in_grant) begin
        if (m_grp.size() != 0 && m_abort < 255) m_abort++;
        m_grp.delete();
        m_grp.push_back(int'(bus.in_data));
      end else if (m_grp.size() != 0) begin
        m_grp.push_back(int'(bus.in_data));
        if (m_grp.size() == 4) begin
          e = make_entry(m_grp[0], m_grp[1], m_grp[2], m_grp[3]);
          m_grp.delete();
          done = 1'b1;
        end
      end
      if (do_pop) void'(m_fifo.pop_front());
      if (done) begin
        if (m_fifo.size() == DEPTH) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_fifo.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("res_valid", 32'(bus.res_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
        chk("res_d",   32'(bus.res_d),   32'(m_fifo[0].d));
        chk("res_sum", 32'(bus.res_sum), 32'(m_fifo[0].sum));
        chk("res_err", 32'(bus.res_err), 32'(m_fifo[0].err));
      end
      chk("drop_cnt",  32'(bus.drop_cnt),  32'(m_drop));
      chk("abort_cnt", 32'(bus.abort_cnt), 32'(m_abort));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic g, input int data, input logic rdy);
    bus.in_grant  = g;
    bus.in_data   = IN_W'(data);
    bus.res_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic group(input int x1, input int x3, input int x7, input int x8, input logic rdy);
    drive(1'b1, x1, rdy);
    drive(1'b0, x3, rdy);
    drive(1'b0, x7, rdy);
    drive(1'b0, x8, rdy);
  endtask

  initial begin
    bus.in_grant  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_d",     32'(bus.res_d),     32'd0);
    chk("rst_sum",   32'(bus.res_sum),   32'd0);
    chk("rst_err",   32'(bus.res_err),   32'd0);
    rst = 1'b1;
    drive(1'b0, 0, 1'b0);
    chk("rst_drop",  32'(bus.drop_cnt),  32'd0);
    chk("rst_abort", 32'(bus.abort_cnt), 32'd0);

    // Basic group d=5 and its latency.
    drive(1'b1, 5, 1'b0);
    drive(1'b0, 15, 1'b0);
    drive(1'b0, 35, 1'b0);
    chk("lat_valid_early", 32'(bus.res_valid), 32'd0);
    drive(1'b0, 40, 1'b0);
    chk("g5_valid", 32'(bus.res_valid), 32'd1);
    chk("g5_d",     32'(bus.res_d),     32'd5);
    chk("g5_sum",   32'(bus.res_sum),   32'd95);
    chk("g5_err",   32'(bus.res_err),   32'd0);
    chk("model_g5_sum", 32'(m_fifo[0].sum), 32'd95);
    drive(1'b0, 0, 1'b1);
    chk("g5_popped", 32'(bus.res_valid), 32'd0);

    // Largest consistent operand, consumer always ready.
    group(255, 765, 1785, 2040, 1'b1);
    chk("g255_sum",   32'(bus.res_sum),   32'd4845);
    chk("g255_err",   32'(bus.res_err),   32'd0);
    chk("g255_valid", 32'(bus.res_valid), 32'd1);
    drive(1'b0, 0, 1'b1);
    chk("g255_one_cycle", 32'(bus.res_valid), 32'd0);

    // Inconsistent groups.
    group(10, 30, 71, 80, 1'b1);
    chk("bad7_sum", 32'(bus.res_sum), 32'd191);
    chk("bad7_err", 32'(bus.res_err), 32'd1);
    group(300, 900, 2100, 2400 % 2048, 1'b1);
    chk("big_d",   32'(bus.res_d),   32'd44);
    chk("big_err", 32'(bus.res_err), 32'd1);
    chk("model_big_err", 32'(m_fifo[0].err), 32'd1);
    drive(1'b0, 0, 1'b1);

    // Early grant aborts a partial group.
    drive(1'b1, 7, 1'b1);
    drive(1'b0, 21, 1'b1);
    group(3, 9, 21, 24, 1'b1);
    chk("abort_cnt", 32'(bus.abort_cnt), 32'd1);
    chk("abort_d",   32'(bus.res_d),     32'd3);
    chk("abort_sum", 32'(bus.res_sum),   32'd57);
    drive(1'b0, 0, 1'b1);

    // Overflow: five groups into a four-entry FIFO.
    for (int d = 1; d <= 5; d++) group(d, 3 * d, 7 * d, 8 * d, 1'b0);
    chk("ovf_drop", 32'(bus.drop_cnt), 32'd1);
    for (int d = 1; d <= 4; d++) begin
      chk("ovf_order", 32'(bus.res_d), 32'(d));
      drive(1'b0, 0, 1'b1);
    end
    chk("ovf_empty", 32'(bus.res_valid), 32'd0);

    // Full FIFO with a pop on the push edge: nothing dropped.
    for (int d = 1; d <= 4; d++) group(d, 3 * d, 7 * d, 8 * d, 1'b0);
    drive(1'b1, 5, 1'b0);
    drive(1'b0, 15, 1'b0);
    drive(1'b0, 35, 1'b0);
    drive(1'b0, 40, 1'b1);
    chk("popfull_drop", 32'(bus.drop_cnt), 32'd1);
    for (int d = 2; d <= 5; d++) begin
      chk("popfull_order", 32'(bus.res_d), 32'(d));
      drive(1'b0, 0, 1'b1);
    end

    // Reset in the middle of a group with two entries queued.
    group(7, 21, 49, 56, 1'b0);
    group(9, 27, 63, 72, 1'b0);
    drive(1'b1, 4, 1'b0);
    drive(1'b0, 12, 1'b0);
    chk("pre_rst_valid", 32'(bus.res_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_drop",  32'(bus.drop_cnt),  32'd0);
    chk("mid_rst_abort", 32'(bus.abort_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    group(6, 18, 42, 48, 1'b0);
    chk("post_rst_d",   32'(bus.res_d),   32'd6);
    chk("post_rst_sum", 32'(bus.res_sum), 32'd114);
    chk("post_rst_err", 32'(bus.res_err), 32'd0);
    drive(1'b0, 0, 1'b1);

    // Randomized traffic: clean, corrupted, partial and oversized groups.
    for (int g = 0; g < 120; g++) begin
      automatic int kind   = $urandom_range(0, 9);
      automatic int d      = (kind == 0) ? $urandom_range(256, 2047) : $urandom_range(0, 255);
      automatic int nwords = (kind == 1) ? $urandom_range(1, 3) : 4;
      automatic int bad    = $urandom_range(1, 3);
      automatic int idle   = $urandom_range(0, 2);
      for (int w = 0; w < nwords; w++) begin
        automatic int mult = (w == 0) ? 1 : (w == 1) ? 3 : (w == 2) ? 7 : 8;
        automatic int word = (d * mult) % 2048;
        if (kind == 2 && w == bad) word = word ^ (1 << $urandom_range(0, 10));
        drive(w == 0, word, $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < idle; i++) drive(1'b0, $urandom_range(0, 2047), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 8; i++) drive(1'b0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_sel_collect.md
Name: multi_sel_collect

Overview:
- Downstream consumer of the multi_sel sequential multiplier stage.
- Takes its grant-framed 4-word product stream (d*1, d*3, d*7, d*8 on consecutive cycles) and reassembles each group.
- Checks each group for consistency, forms the sum d*19, and queues results in a small FIFO behind a valid/ready handshake.

Parameters:
- IN_W, 11, width of incoming product word
- D_W, 8, width of recovered operand d
- SUM_W, 13, width of group sum (255*19 = 4845 < 8192)
- FIFO_DEPTH, 4, result FIFO entries (power of 2, >= 2)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- in_grant  input  1  upstream input_grant; high marks the d*1 word of a group
- in_data  input  IN_W  upstream out word
- res_valid  output  1  FIFO head valid (FIFO not empty)
- res_ready  input  1  consumer accepts head when res_valid & res_ready
- res_d  output  D_W  recovered d (x1[D_W-1:0]) of head entry
- res_sum  output  SUM_W  x1+x3+x7+x8 of head entry
- res_err  output  1  head entry failed consistency check
- drop_cnt  output  8  groups dropped because FIFO full, saturates at 255
- abort_cnt  output  8  groups restarted by an early grant, saturates at 255

Behaviour:
- Reset (rst low, async): FSM to S_IDLE; capture registers, FIFO pointers/count, drop_cnt, abort_cnt cleared; res_valid=0, res_d=0, res_sum=0, res_err=0.
- Sampling: in_grant and in_data are sampled together each rising edge; a word is x1 when sampled with in_grant=1.
- FSM states: S_IDLE, S_P3, S_P7, S_P8.
  - in_grant=1 in any state: capture x1, go to S_P3. If the state was S_P3/S_P7/S_P8, the partial group is discarded and abort_cnt increments (saturating); nothing is pushed.
  - S_IDLE, in_grant=0: stay, ignore data.
  - S_P3, in_grant=0: capture x3, go to S_P7.
  - S_P7, in_grant=0: capture x7, go to S_P8.
  - S_P8, in_grant=0: take x8 from in_data, complete the group, go to S_IDLE.
- Completion: on the x8 edge, compute an entry from the registered x1/x3/x7 and the live x8, and push it on that same edge.
  - sum: zero-extend all four words to SUM_W, then add; no truncation.
  - err = (x1[IN_W-1:D_W] != 0) | (x3 != 3*x1) | (x7 != 7*x1) | (x8 != 8*x1). Compares are done at SUM_W width.
  - res_d = x1[D_W-1:0].
- Latency: res_valid rises the cycle after the x8 edge when the FIFO was empty, i.e. 4 cycles after the grant edge.
- FIFO: first-word-fall-through; res_d/res_sum/res_err show the head while res_valid=1.
  - Pop on res_valid & res_ready.
  - Push when a group completes.
  - Full with no pop: the push is dropped and drop_cnt increments (saturating).
  - Full with a simultaneous pop: the push is accepted and the count is unchanged.
  - Empty with a push: res_valid rises next cycle; no bypass.
  - res_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Output stability: head outputs are stable while res_valid=1 and res_ready=0.
- Reset mid-group or mid-drain: everything is lost; no partial push.
- Counters never wrap; they clear only on reset.

Test Plan:
- Reset, then grant with 5, then 15, 35, 40 (grant low) -> one entry: res_d=5, res_sum=95, res_err=0, res_valid on cycle 4 after grant edge.
- Group for d=255 (255, 765, 1785, 2040) with res_ready=1 -> res_sum=4845, res_err=0, res_valid high for exactly 1 cycle.
- Group 10, 30, 71, 80 -> res_sum=191, res_err=1. Group 300, 900, 2100, 2400 (x1 > 255) -> res_err=1, res_d=44.
- Grant, 2 words, then grant again and a full group for d=3 -> abort_cnt=1, single entry res_d=3, res_sum=57.
- res_ready=0 with 5 back-to-back groups d=1..5 -> 4 entries held, drop_cnt=1. Raise res_ready -> read order d=1,2,3,4. Repeat with a pop on the 5th push edge -> no drop.
- Assert rst low during S_P7 and with 2 FIFO entries -> res_valid=0 and both counters 0 immediately. A fresh group after release completes normally.
